// File: rtl/sy_pkg.sv
// Shared types for the physical register file: default geometry, preg index and writeback bus.
package sy_pkg;
  localparam int PHY_REG     = 64;
  localparam int PHY_REG_WTH = $clog2(PHY_REG);
  localparam int DWTH        = 64;

  typedef logic [PHY_REG_WTH-1:0] preg_idx_t;

  typedef struct packed {
    logic            en;
    preg_idx_t       idx;
    logic [DWTH-1:0] data;
  } wb_bus_t;
endpackage

// File: rtl/sy_ppl_prf_wr_sel.sv
// Priority select over the writeback ports for one index: highest-numbered matching port wins.
module sy_ppl_prf_wr_sel
  import sy_pkg::*;
#(
  parameter int  NR_WR  = 5,
  parameter int  IDX_W  = PHY_REG_WTH,
  parameter int  DWTH_P = DWTH,
  parameter type WB_T   = wb_bus_t
) (
  input  WB_T [NR_WR-1:0]  wb,
  input  logic [IDX_W-1:0] sel_idx,
  output logic             hit,
  output logic [DWTH_P-1:0] data,
  output logic             multi
);

  always_comb begin
    hit   = 1'b0;
    multi = 1'b0;
    data  = '0;
    for (int i = 0; i < NR_WR; i++) begin
      if (wb[i].en && (wb[i].idx == sel_idx)) begin
        multi = multi | hit;
        hit   = 1'b1;
        data  = wb[i].data;
      end
    end
  end

endmodule

// File: rtl/sy_ppl_prf_sb.sv
// Physical register file with per-register ready scoreboard, write-port priority and optional bypass.
module sy_ppl_prf_sb
  import sy_pkg::*;
#(
  parameter int NR_RD    = 5,
  parameter int NR_WR    = 5,
  parameter int NR_PREG  = PHY_REG,
  parameter int DWTH_P   = 64,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  parameter int IDX_W    = $clog2(NR_PREG)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NR_RD-1:0][IDX_W-1:0]   rd_idx_i,
  output logic [NR_RD-1:0][DWTH_P-1:0]  rd_data_o,
  output logic [NR_RD-1:0]              rd_rdy_o,
  input  logic [NR_WR-1:0]              wr_en_i,
  input  logic [NR_WR-1:0][IDX_W-1:0]   wr_idx_i,
  input  logic [NR_WR-1:0][DWTH_P-1:0]  wr_data_i,
  input  logic                          alloc_en_i,
  input  logic [IDX_W-1:0]              alloc_idx_i,
  input  logic                          flush_i,
  output logic                          wr_conflict_o
);

  typedef struct packed {
    logic              en;
    logic [IDX_W-1:0]  idx;
    logic [DWTH_P-1:0] data;
  } wb_t;

  wb_t [NR_WR-1:0]     wb;
  logic [DWTH_P-1:0]   mem_q [NR_PREG];
  logic [NR_PREG-1:0]  rdy_q;
  logic [NR_PREG-1:0]  multi_v;
  logic                conflict_q;

  for (genvar w = 0; w < NR_WR; w++) begin : g_wb
    assign wb[w].en   = wr_en_i[w];
    assign wb[w].idx  = wr_idx_i[w];
    assign wb[w].data = wr_data_i[w];
  end

  for (genvar r = 0; r < NR_PREG; r++) begin : g_reg
    if ((ZERO_REG != 0) && (r == 0)) begin : g_zero
      assign mem_q[r]   = '0;
      assign rdy_q[r]   = 1'b1;
      assign multi_v[r] = 1'b0;
    end else begin : g_live
      logic              hit;
      logic              multi;
      logic [DWTH_P-1:0] wdata;
      logic [DWTH_P-1:0] q;
      logic              rq;
      logic              alloc_hit;

      sy_ppl_prf_wr_sel #(
        .NR_WR  (NR_WR),
        .IDX_W  (IDX_W),
        .DWTH_P (DWTH_P),
        .WB_T   (wb_t)
      ) u_sel (
        .wb      (wb),
        .sel_idx (IDX_W'(r)),
        .hit     (hit),
        .data    (wdata),
        .multi   (multi)
      );

      assign alloc_hit = alloc_en_i && (alloc_idx_i == IDX_W'(r));

      // Flush beats alloc, and alloc beats a same-cycle writeback (new producer pending).
      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          q  <= '0;
          rq <= 1'b1;
        end else begin
          if (hit) q <= wdata;
          if (flush_i)        rq <= 1'b1;
          else if (alloc_hit) rq <= 1'b0;
          else if (hit)       rq <= 1'b1;
        end
      end

      assign mem_q[r]   = q;
      assign rdy_q[r]   = rq;
      assign multi_v[r] = multi;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) conflict_q <= 1'b0;
    else        conflict_q <= conflict_q | (|multi_v);
  end

  assign wr_conflict_o = conflict_q;

  for (genvar p = 0; p < NR_RD; p++) begin : g_rd
    logic              byp_hit;
    logic [DWTH_P-1:0] byp_data;
    logic              byp_multi_unused;
    logic [DWTH_P-1:0] d;
    logic              rd;

    sy_ppl_prf_wr_sel #(
      .NR_WR  (NR_WR),
      .IDX_W  (IDX_W),
      .DWTH_P (DWTH_P),
      .WB_T   (wb_t)
    ) u_byp (
      .wb      (wb),
      .sel_idx (rd_idx_i[p]),
      .hit     (byp_hit),
      .data    (byp_data),
      .multi   (byp_multi_unused)
    );

    // Unmapped and hardwired-zero indices read as a ready zero.
    always_comb begin
      d  = '0;
      rd = 1'b1;
      if ((int'(rd_idx_i[p]) < NR_PREG) &&
          !((ZERO_REG != 0) && (rd_idx_i[p] == '0))) begin
        if ((BYPASS != 0) && byp_hit) begin
          d  = byp_data;
          rd = 1'b1;
        end else begin
          d  = mem_q[rd_idx_i[p]];
          rd = rdy_q[rd_idx_i[p]];
        end
      end
    end

    assign rd_data_o[p] = d;
    assign rd_rdy_o[p]  = rd;
  end

endmodule

// File: tb/tb_sy_ppl_prf_sb.sv
// Bench for sy_ppl_prf_sb: two instances (bypass/64 regs, no-bypass/40 regs) against a behavioural model.
module tb_sy_ppl_prf_sb;
  localparam int NRD = 5;
  localparam int NWR = 5;

  logic clk = 1'b0;
  logic rst;
  logic [NRD-1:0][5:0]  rd_idx;
  logic [NWR-1:0]       wr_en;
  logic [NWR-1:0][5:0]  wr_idx;
  logic [NWR-1:0][63:0] wr_data;
  logic                 alloc_en;
  logic [5:0]           alloc_idx;
  logic                 flush;

  logic [NRD-1:0][63:0] rdd [2];
  logic [NRD-1:0]       rdy [2];
  logic                 conf [2];

  int checks = 0;
  int errors = 0;

  int          np [2] = '{64, 40};
  bit          bp [2] = '{1'b1, 1'b0};
  logic [63:0] md [2][64];
  bit          mr [2][64];
  bit          mc [2];

  always #5 clk = ~clk;

  sy_ppl_prf_sb #(.NR_PREG(64), .BYPASS(1)) u_a (
    .clk_i(clk), .rst_i(rst), .rd_idx_i(rd_idx), .rd_data_o(rdd[0]), .rd_rdy_o(rdy[0]),
    .wr_en_i(wr_en), .wr_idx_i(wr_idx), .wr_data_i(wr_data), .alloc_en_i(alloc_en),
    .alloc_idx_i(alloc_idx), .flush_i(flush), .wr_conflict_o(conf[0]));

  sy_ppl_prf_sb #(.NR_PREG(40), .BYPASS(0)) u_b (
    .clk_i(clk), .rst_i(rst), .rd_idx_i(rd_idx), .rd_data_o(rdd[1]), .rd_rdy_o(rdy[1]),
    .wr_en_i(wr_en), .wr_idx_i(wr_idx), .wr_data_i(wr_data), .alloc_en_i(alloc_en),
    .alloc_idx_i(alloc_idx), .flush_i(flush), .wr_conflict_o(conf[1]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 64; r++) begin
        md[k][r] = '0;
        mr[k][r] = 1'b1;
      end
      mc[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      for (int r = 1; r < np[k]; r++) begin
        int          cnt = 0;
        logic [63:0] d = '0;
        for (int p = 0; p < NWR; p++)
          if (wr_en[p] && int'(wr_idx[p]) == r) begin cnt++; d = wr_data[p]; end
        if (cnt > 0) md[k][r] = d;
        if (cnt > 1) mc[k] = 1'b1;
        if (flush)                                   mr[k][r] = 1'b1;
        else if (alloc_en && int'(alloc_idx) == r)   mr[k][r] = 1'b0;
        else if (cnt > 0)                            mr[k][r] = 1'b1;
      end
    end
  endtask

  function automatic logic [64:0] exp_rd(input int k, input int idx);
    logic [64:0] res;
    if (idx >= np[k] || idx == 0) return {1'b1, 64'h0};
    res = {mr[k][idx], md[k][idx]};
    if (bp[k])
      for (int p = 0; p < NWR; p++)
        if (wr_en[p] && int'(wr_idx[p]) == idx) res = {1'b1, wr_data[p]};
    return res;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < NRD; p++) begin
        logic [64:0] e;
        e = exp_rd(k, int'(rd_idx[p]));
        chk($sformatf("model data inst%0d port%0d", k, p), rdd[k][p], e[63:0]);
        chk($sformatf("model rdy inst%0d port%0d", k, p), 64'(rdy[k][p]), 64'(e[64]));
      end
      chk($sformatf("model conflict inst%0d", k), 64'(conf[k]), 64'(mc[k]));
    end
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    wr_en = '0; wr_data = '0; wr_idx = '0;
    alloc_en = 1'b0; alloc_idx = '0; flush = 1'b0;
  endtask

  function automatic logic [5:0] rnd_idx();
    return ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
  endfunction

  initial begin
    rst = 1'b0;
    model_reset();
    clear();
    rd_idx = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // reset state
    rd_idx[0] = 6'd5; rd_idx[1] = 6'd0; rd_idx[2] = 6'd63;
    @(negedge clk);
    chk("t1 data port0", rdd[0][0], 64'h0);
    chk("t1 data port2", rdd[0][2], 64'h0);
    chk("t1 rdy all", 64'(rdy[0]), 64'h1f);
    chk("t1 conflict", 64'(conf[0]), 64'h0);

    // same-cycle bypass vs stored read
    go(); clear();
    wr_en[2] = 1'b1; wr_idx[2] = 6'd7; wr_data[2] = 64'hDEAD; rd_idx[0] = 6'd7;
    @(negedge clk);
    chk("t2 bypass data", rdd[0][0], 64'hDEAD);
    chk("t2 bypass rdy", 64'(rdy[0][0]), 64'h1);
    chk("t2 nobypass data", rdd[1][0], 64'h0);
    go(); clear();
    @(negedge clk);
    chk("t2 stored a", rdd[0][0], 64'hDEAD);
    chk("t2 stored b", rdd[1][0], 64'hDEAD);

    // port priority and sticky conflict
    go(); clear();
    wr_en[1] = 1'b1; wr_idx[1] = 6'd12; wr_data[1] = 64'h11;
    wr_en[4] = 1'b1; wr_idx[4] = 6'd12; wr_data[4] = 64'h44;
    rd_idx[1] = 6'd12;
    @(negedge clk);
    chk("t3 bypass prio", rdd[0][1], 64'h44);
    chk("t3 conflict not yet", 64'(conf[0]), 64'h0);
    go(); clear();
    @(negedge clk);
    chk("t3 stored prio", rdd[1][1], 64'h44);
    chk("t3 conflict a", 64'(conf[0]), 64'h1);
    chk("t3 conflict b", 64'(conf[1]), 64'h1);
    repeat (3) go();
    @(negedge clk);
    chk("t3 conflict held", 64'(conf[0]), 64'h1);
    go(); rst = 1'b0; #2 rst = 1'b1;
    @(negedge clk);
    chk("t3 conflict cleared", 64'(conf[0]), 64'h0);

    // alloc / writeback / alloc+write
    go(); clear();
    alloc_en = 1'b1; alloc_idx = 6'd9; rd_idx[2] = 6'd9;
    @(negedge clk);
    chk("t4 rdy before edge", 64'(rdy[0][2]), 64'h1);
    go(); clear();
    @(negedge clk);
    chk("t4 alloc rdy a", 64'(rdy[0][2]), 64'h0);
    chk("t4 alloc rdy b", 64'(rdy[1][2]), 64'h0);
    go(); clear();
    wr_en[0] = 1'b1; wr_idx[0] = 6'd9; wr_data[0] = 64'h55;
    @(negedge clk);
    chk("t4 wb bypass rdy", 64'(rdy[0][2]), 64'h1);
    chk("t4 wb nobypass rdy", 64'(rdy[1][2]), 64'h0);
    go(); clear();
    @(negedge clk);
    chk("t4 wb data", rdd[1][2], 64'h55);
    chk("t4 wb rdy", 64'(rdy[1][2]), 64'h1);
    go(); clear();
    alloc_en = 1'b1; alloc_idx = 6'd9;
    wr_en[0] = 1'b1; wr_idx[0] = 6'd9; wr_data[0] = 64'h55;
    go(); clear();
    @(negedge clk);
    chk("t4 alloc+wr data", rdd[0][2], 64'h55);
    chk("t4 alloc+wr rdy", 64'(rdy[0][2]), 64'h0);

    // flush overrides alloc
    rd_idx[0] = 6'd20; rd_idx[1] = 6'd21; rd_idx[2] = 6'd22;
    go(); clear(); alloc_en = 1'b1; alloc_idx = 6'd20;
    go(); clear(); alloc_en = 1'b1; alloc_idx = 6'd21;
    go(); clear(); alloc_en = 1'b1; alloc_idx = 6'd22; flush = 1'b1;
    @(negedge clk);
    chk("t5 pre-flush rdy", 64'(rdy[0][2:0]), 64'h4);
    go(); clear();
    @(negedge clk);
    chk("t5 flush rdy a", 64'(rdy[0][2:0]), 64'h7);
    chk("t5 flush rdy b", 64'(rdy[1][2:0]), 64'h7);

    // hardwired zero register
    go(); clear();
    wr_en[0] = 1'b1; wr_idx[0] = 6'd0; wr_data[0] = 64'hFF;
    wr_en[3] = 1'b1; wr_idx[3] = 6'd0; wr_data[3] = 64'hFF;
    rd_idx[3] = 6'd0;
    @(negedge clk);
    chk("t5 zero bypass", rdd[0][3], 64'h0);
    go(); clear();
    @(negedge clk);
    chk("t5 zero stored", rdd[0][3], 64'h0);
    chk("t5 zero no conflict", 64'(conf[0]), 64'h0);

    // index beyond a 40-entry file
    go(); clear();
    wr_en[0] = 1'b1; wr_idx[0] = 6'd45; wr_data[0] = 64'h45; rd_idx[4] = 6'd45;
    @(negedge clk);
    chk("oor read b", rdd[1][4], 64'h0);
    chk("oor bypass a", rdd[0][4], 64'h45);
    go(); clear();
    @(negedge clk);
    chk("oor stored b", rdd[1][4], 64'h0);
    chk("oor conflict b", 64'(conf[1]), 64'h0);

    // asynchronous reset mid-cycle
    go(); clear();
    wr_en[1] = 1'b1; wr_idx[1] = 6'd3; wr_data[1] = 64'hABC;
    wr_en[2] = 1'b1; wr_idx[2] = 6'd3; wr_data[2] = 64'hABD;
    rd_idx[0] = 6'd3;
    go(); clear();
    @(negedge clk);
    chk("t6 pre data", rdd[0][0], 64'hABD);
    chk("t6 pre conflict", 64'(conf[0]), 64'h1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("t6 async data a", rdd[0][0], 64'h0);
    chk("t6 async data b", rdd[1][0], 64'h0);
    chk("t6 async conflict", 64'(conf[0]), 64'h0);
    #2 rst = 1'b1;

    // randomized traffic
    repeat (3000) begin
      go();
      for (int p = 0; p < NWR; p++) begin
        wr_en[p]   = ($urandom_range(0, 2) == 0);
        wr_idx[p]  = rnd_idx();
        wr_data[p] = {$urandom, $urandom};
      end
      for (int p = 0; p < NRD; p++) rd_idx[p] = rnd_idx();
      alloc_en  = ($urandom_range(0, 2) == 0);
      alloc_idx = rnd_idx();
      flush     = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b0;
        #1 rst = 1'b1;
      end
    end
    go(); clear();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
